// File: rtl/bin_to_bcd_seq_if.sv
// Start/result bundle for the sequential binary-to-BCD converter.
// master drives the request; slave is the converter.
interface bin_to_bcd_seq_if;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        overflow;
  logic [5:0]  lz_mask;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow,
    input  lz_mask
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output overflow,
    output lz_mask
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble converter: 20-bit binary to six packed BCD digits plus blanking mask.
// Latency: done pulses 21 edges after start is accepted; busy is high for those 21 cycles.
// No backpressure: start is only honoured in IDLE, otherwise dropped without queuing.
module bin_to_bcd_seq #(
  parameter int unsigned CLAMP_ON_OVF = 1
) (
  input logic             CLOCK_50,
  input logic             reset,
  bin_to_bcd_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [19:0] MAX_DEC   = 20'd999999;
  localparam logic [4:0]  NUM_BITS  = 5'd20;
  localparam logic [23:0] CLAMP_VAL = 24'h999999;

  state_t      state_q;
  state_t      state_d;
  logic [27:0] acc_q;
  logic [27:0] acc_adj;
  logic [19:0] opnd_q;
  logic [4:0]  cnt_q;
  logic        ovf_pend_q;

  logic        load_en;
  logic        shift_en;
  logic        commit_en;

  logic [23:0] res_bcd;
  logic [5:0]  res_lz;
  logic        all_zero;

  logic        done_q;
  logic [23:0] bcd_q;
  logic        ovf_q;
  logic [5:0]  lz_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_en = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        commit_en = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Add-3 correction on every digit before the shift keeps each digit in 0-9 after doubling.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 7; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else if (load_en) begin
      acc_q      <= '0;
      opnd_q     <= bus.bin_in;
      cnt_q      <= NUM_BITS;
      ovf_pend_q <= (bus.bin_in > MAX_DEC);
    end else if (shift_en) begin
      acc_q  <= {acc_adj[26:0], opnd_q[19]};
      opnd_q <= {opnd_q[18:0], 1'b0};
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  always_comb begin
    if (ovf_pend_q && (CLAMP_ON_OVF != 0)) begin
      res_bcd = CLAMP_VAL;
    end else begin
      res_bcd = acc_q[23:0];
    end
  end

  // Blank from the most significant digit downward; the units digit is always shown.
  always_comb begin
    res_lz   = '0;
    all_zero = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      all_zero  = all_zero && (res_bcd[4*i +: 4] == 4'd0);
      res_lz[i] = all_zero;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      done_q <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      lz_q   <= 6'b111110;
    end else begin
      done_q <= commit_en;
      if (commit_en) begin
        bcd_q <= res_bcd;
        ovf_q <= ovf_pend_q;
        lz_q  <= res_lz;
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.lz_mask  = lz_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq; a clamping and a wrapping instance run in lockstep.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #10 clk = ~clk;

  bin_to_bcd_seq_if ifc_c ();
  bin_to_bcd_seq_if ifc_w ();

  bin_to_bcd_seq #(.CLAMP_ON_OVF(1)) dut_c (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (ifc_c)
  );

  bin_to_bcd_seq #(.CLAMP_ON_OVF(0)) dut_w (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (ifc_w)
  );

  task automatic drive(input logic s, input logic [19:0] v);
    ifc_c.start  = s;
    ifc_c.bin_in = v;
    ifc_w.start  = s;
    ifc_w.bin_in = v;
  endtask

  // Leaves the caller at the falling edge just after the accepting edge T.
  task automatic launch(input logic [19:0] v);
    @(negedge clk);
    drive(1'b1, v);
    @(negedge clk);
    drive(1'b0, 20'h0);
  endtask

  // lat = number of edges after T at which done is first seen (0 if never).
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = ifc_c.busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ifc_c.done) begin
        lat = k;
        break;
      end
      if (ifc_c.busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 20'h0);
    repeat (2) @(negedge clk);
    n_cmp++; if (ifc_c.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", ifc_c.busy); end
    n_cmp++; if (ifc_c.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", ifc_c.done); end
    n_cmp++; if (ifc_c.bcd_out !== 24'h000000) begin n_bad++; $display("FAIL reset_bcd: got %h want 000000", ifc_c.bcd_out); end
    n_cmp++; if (ifc_c.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ifc_c.overflow); end
    n_cmp++; if (ifc_c.lz_mask !== 6'b111110) begin n_bad++; $display("FAIL reset_lz: got %b want 111110", ifc_c.lz_mask); end
    n_cmp++; if (ifc_w.lz_mask !== 6'b111110) begin n_bad++; $display("FAIL reset_lz_w: got %b want 111110", ifc_w.lz_mask); end
    // Reset held while start is raised must win.
    drive(1'b1, 20'd77);
    @(negedge clk);
    n_cmp++; if (ifc_c.busy !== 1'b0) begin n_bad++; $display("FAIL reset_prio_busy: got %b want 0", ifc_c.busy); end
    drive(1'b0, 20'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ifc_c.busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_start: got %b want 0", ifc_c.busy); end
  endtask

  task automatic test_convert(input string name, input logic [19:0] v,
                              input logic [23:0] exp_bcd, input logic [5:0] exp_lz);
    int lat;
    int busy_n;
    launch(v);
    wait_done(lat, busy_n);
    n_cmp++; if (lat !== 21) begin n_bad++; $display("FAIL %s_latency: got %0d want 21", name, lat); end
    n_cmp++; if (busy_n !== 21) begin n_bad++; $display("FAIL %s_busy_cycles: got %0d want 21", name, busy_n); end
    n_cmp++; if (ifc_c.busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_at_done: got %b want 0", name, ifc_c.busy); end
    n_cmp++; if (ifc_c.bcd_out !== exp_bcd) begin n_bad++; $display("FAIL %s_bcd: got %h want %h", name, ifc_c.bcd_out, exp_bcd); end
    n_cmp++; if (ifc_c.overflow !== 1'b0) begin n_bad++; $display("FAIL %s_ovf: got %b want 0", name, ifc_c.overflow); end
    n_cmp++; if (ifc_c.lz_mask !== exp_lz) begin n_bad++; $display("FAIL %s_lz: got %b want %b", name, ifc_c.lz_mask, exp_lz); end
    n_cmp++; if (ifc_w.bcd_out !== exp_bcd) begin n_bad++; $display("FAIL %s_bcd_w: got %h want %h", name, ifc_w.bcd_out, exp_bcd); end
    @(negedge clk);
    n_cmp++; if (ifc_c.done !== 1'b0) begin n_bad++; $display("FAIL %s_done_width: got %b want 0", name, ifc_c.done); end
  endtask

  task automatic test_overflow();
    int lat;
    int busy_n;
    launch(20'd1048575);
    wait_done(lat, busy_n);
    n_cmp++; if (lat !== 21) begin n_bad++; $display("FAIL ovf_latency: got %0d want 21", lat); end
    n_cmp++; if (ifc_c.bcd_out !== 24'h999999) begin n_bad++; $display("FAIL ovf_clamp_bcd: got %h want 999999", ifc_c.bcd_out); end
    n_cmp++; if (ifc_c.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_clamp_flag: got %b want 1", ifc_c.overflow); end
    n_cmp++; if (ifc_c.lz_mask !== 6'b000000) begin n_bad++; $display("FAIL ovf_clamp_lz: got %b want 000000", ifc_c.lz_mask); end
    n_cmp++; if (ifc_w.done !== 1'b1) begin n_bad++; $display("FAIL ovf_wrap_done: got %b want 1", ifc_w.done); end
    n_cmp++; if (ifc_w.bcd_out !== 24'h048575) begin n_bad++; $display("FAIL ovf_wrap_bcd: got %h want 048575", ifc_w.bcd_out); end
    n_cmp++; if (ifc_w.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_wrap_flag: got %b want 1", ifc_w.overflow); end
    n_cmp++; if (ifc_w.lz_mask !== 6'b100000) begin n_bad++; $display("FAIL ovf_wrap_lz: got %b want 100000", ifc_w.lz_mask); end
  endtask

  // Outputs must stay put while idle, whatever bin_in does.
  task automatic test_hold();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(1'b0, 20'(k * 4111 + 3));
    end
    @(negedge clk);
    n_cmp++; if (ifc_c.bcd_out !== 24'h999999) begin n_bad++; $display("FAIL hold_bcd: got %h want 999999", ifc_c.bcd_out); end
    n_cmp++; if (ifc_c.overflow !== 1'b1) begin n_bad++; $display("FAIL hold_ovf: got %b want 1", ifc_c.overflow); end
    n_cmp++; if (ifc_w.bcd_out !== 24'h048575) begin n_bad++; $display("FAIL hold_bcd_w: got %h want 048575", ifc_w.bcd_out); end
    n_cmp++; if (ifc_c.done !== 1'b0) begin n_bad++; $display("FAIL hold_done: got %b want 0", ifc_c.done); end
    n_cmp++; if (ifc_c.busy !== 1'b0) begin n_bad++; $display("FAIL hold_busy: got %b want 0", ifc_c.busy); end
    drive(1'b0, 20'h0);
  endtask

  task automatic test_start_ignored();
    int done_n = 0;
    int first  = 0;
    launch(20'd500);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) drive(1'b1, 20'd7);
      if (k == 5) drive(1'b0, 20'h0);
      if (ifc_c.done) begin
        done_n++;
        if (first == 0) first = k;
        n_cmp++; if (ifc_c.bcd_out !== 24'h000500) begin n_bad++; $display("FAIL busy_start_bcd: got %h want 000500", ifc_c.bcd_out); end
        n_cmp++; if (ifc_c.lz_mask !== 6'b111000) begin n_bad++; $display("FAIL busy_start_lz: got %b want 111000", ifc_c.lz_mask); end
      end
    end
    n_cmp++; if (done_n !== 1) begin n_bad++; $display("FAIL busy_start_done_count: got %0d want 1", done_n); end
    n_cmp++; if (first !== 21) begin n_bad++; $display("FAIL busy_start_latency: got %0d want 21", first); end
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    launch(20'd4321);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (ifc_c.busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", ifc_c.busy); end
    n_cmp++; if (ifc_c.bcd_out !== 24'h000000) begin n_bad++; $display("FAIL mid_reset_bcd: got %h want 000000", ifc_c.bcd_out); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ifc_c.done) done_n++;
    end
    n_cmp++; if (done_n !== 0) begin n_bad++; $display("FAIL mid_reset_done_count: got %0d want 0", done_n); end
    test_convert("after_reset_9", 20'd9, 24'h000009, 6'b111110);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 20'h0);
    test_reset();
    test_convert("zero", 20'd0, 24'h000000, 6'b111110);
    test_convert("d12345", 20'd12345, 24'h012345, 6'b100000);
    test_convert("d999999", 20'hF423F, 24'h999999, 6'b000000);
    test_convert("d80", 20'd80, 24'h000080, 6'b111100);
    test_overflow();
    test_hold();
    test_convert("d654321", 20'd654321, 24'h654321, 6'b000000);
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
